// File: rtl/bsg_aes_decrypt_multicycle.sv
// Iterative AES-128 decryptor: one key-expansion or inverse round per clock, valid/ready in, valid/yumi out.
// Optional key cache enabled by defining BSG_AES_DECRYPT_KEY_CACHE_EN.
module bsg_aes_decrypt_multicycle #(
    parameter int unsigned in_width_p = 2048
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  v_i,
    input  logic [in_width_p-1:0] data_i,
    output logic                  ready_o,
    output logic                  v_o,
    output logic [127:0]          data_o,
    input  logic                  yumi_i
);

    typedef enum logic [1:0] {StIdle, StKeyExp, StRound, StDone} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq, r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        unique case (i)
            4'd0: return 8'h01;
            4'd1: return 8'h02;
            4'd2: return 8'h04;
            4'd3: return 8'h08;
            4'd4: return 8'h10;
            4'd5: return 8'h20;
            4'd6: return 8'h40;
            4'd7: return 8'h80;
            4'd8: return 8'h1b;
            4'd9: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        w1 = w0 ^ k[95:64];
        w2 = w1 ^ k[63:32];
        w3 = w2 ^ k[31:0];
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] mc_coef(input int k);
        unique case (k)
            0: return 8'h0e;
            1: return 8'h0b;
            2: return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

    // Byte i of a block lives at bits [127-8i -: 8]; byte 4c+r is row r of column c
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   m;
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                a[4*c+rw] = inv_sbox(s[127-8*(4*((c-rw+4)%4)+rw) -: 8]) ^ rk[127-8*(4*c+rw) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                m = 8'h00;
                for (int j = 0; j < 4; j++) m = m ^ gf_mul(mc_coef((j-rw+4)%4), a[4*c+j]);
                r[127-8*(4*c+rw) -: 8] = last ? a[4*c+rw] : m;
            end
        end
        return r;
    endfunction

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] key_q, key_d;
    logic [127:0] data_q, data_d;
    logic [127:0] fwd_key, bwd_key, round_out;
    logic [127:0] ct_in, key_in;

    assign ct_in  = data_i[127:0];
    assign key_in = data_i[255:128];

    if (in_width_p > 256) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^data_i[in_width_p-1:256];
    end

`ifdef BSG_AES_DECRYPT_KEY_CACHE_EN
    logic         cache_v_q, cache_v_d;
    logic [127:0] cache_key_q, cache_key_d;
    logic [127:0] cache_rk_q, cache_rk_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blk_d     = blk_q;
        key_d     = key_q;
        data_d    = data_q;
        fwd_key   = next_key(key_q, rcon(cnt_q));
        bwd_key   = prev_key(key_q, rcon(cnt_q));
        round_out = inv_round(blk_q, bwd_key, cnt_q == 4'd0);
`ifdef BSG_AES_DECRYPT_KEY_CACHE_EN
        cache_v_d   = cache_v_q;
        cache_key_d = cache_key_q;
        cache_rk_d  = cache_rk_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (v_i) begin
                    blk_d   = ct_in;
                    key_d   = key_in;
                    cnt_d   = 4'd0;
                    state_d = StKeyExp;
`ifdef BSG_AES_DECRYPT_KEY_CACHE_EN
                    if (cache_v_q && (cache_key_q == key_in)) begin
                        blk_d   = ct_in ^ cache_rk_q;
                        key_d   = cache_rk_q;
                        cnt_d   = 4'd9;
                        state_d = StRound;
                    end else begin
                        cache_v_d   = 1'b0;
                        cache_key_d = key_in;
                    end
`endif
                end
            end
            StKeyExp: begin
                key_d = fwd_key;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    blk_d   = blk_q ^ fwd_key;
                    cnt_d   = 4'd9;
                    state_d = StRound;
`ifdef BSG_AES_DECRYPT_KEY_CACHE_EN
                    cache_v_d  = 1'b1;
                    cache_rk_d = fwd_key;
`endif
                end
            end
            StRound: begin
                blk_d = round_out;
                key_d = bwd_key;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    data_d  = round_out;
                    cnt_d   = 4'd0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (yumi_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            blk_q   <= '0;
            key_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            data_q  <= data_d;
        end
    end

`ifdef BSG_AES_DECRYPT_KEY_CACHE_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cache_v_q   <= 1'b0;
            cache_key_q <= '0;
            cache_rk_q  <= '0;
        end else begin
            cache_v_q   <= cache_v_d;
            cache_key_q <= cache_key_d;
            cache_rk_q  <= cache_rk_d;
        end
    end
`endif

    assign ready_o = (state_q == StIdle);
    assign v_o     = (state_q == StDone);
    assign data_o  = data_q;

endmodule

// File: tb/tb_bsg_aes_decrypt_multicycle.sv
// Bench for bsg_aes_decrypt_multicycle: random plaintexts are encrypted by a reference AES encryptor
// and fed to the decryptor; latency follows a key-cache model when BSG_AES_DECRYPT_KEY_CACHE_EN is set.
module tb_bsg_aes_decrypt_multicycle;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          v_i;
    logic [2047:0] data_i;
    logic          ready_o;
    logic          v_o;
    logic [127:0]  data_o;
    logic          yumi_i;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   sb [256];
    logic         m_cv;
    logic [127:0] m_ck;

    always #5 clk = ~clk;

    bsg_aes_decrypt_multicycle #(.in_width_p(2048)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Walk generator 3 and its inverse together to fill the S-box
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ xt(p);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) u[4*c+rw] = sb[s[4*((c+rw)%4)+rw]];
            for (int c = 0; c < 4; c++) begin
                a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
                if (rnd < 10) begin
                    u[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    u[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    u[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    u[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int b = 0; b < 16; b++) s[b] = u[b] ^ w[4*rnd + b/4][31-8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) r[127-8*b -: 8] = s[b];
        return r;
    endfunction

    task automatic scramble_data();
        for (int i = 0; i < 64; i++) data_i[32*i +: 32] = $urandom();
    endtask

    // Drives one accepted packet; the caller has already seen ready_o=1
    task automatic do_accept(input logic [127:0] key, input logic [127:0] ct, output int lat);
        logic hit;
        hit = m_cv && (m_ck == key);
`ifdef BSG_AES_DECRYPT_KEY_CACHE_EN
        lat = hit ? 10 : 20;
`else
        lat = 20;
`endif
        m_cv = 1'b1;
        m_ck = key;
        scramble_data();
        data_i[255:0] = {key, ct};
        v_i = 1'b1;
        @(posedge clk);
        #1;
        v_i = 1'b0;
        scramble_data();
    endtask

    // Counts edges until v_o, pulsing ignored v_i/yumi_i meanwhile; bounded at 40
    task automatic wait_valid(output int n);
        n = 0;
        while (v_o !== 1'b1 && n < 40) begin
            yumi_i = 1'($urandom_range(0, 1));
            v_i    = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        yumi_i = 1'b0;
        v_i    = 1'b0;
    endtask

    task automatic retire();
        yumi_i = 1'b1;
        @(posedge clk);
        #1;
        yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        data_i  = '0;
        repeat (10) @(posedge clk);
        #1;
        reset_i = 1'b0;
        m_cv    = 1'b0;
        n_vec++;
        if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset ready_o: got %b want 1", ready_o); end
        n_vec++;
        if (v_o !== 1'b0) begin n_err++; $display("FAIL reset v_o: got %b want 0", v_o); end
        n_vec++;
        if (data_o !== 128'h0) begin n_err++; $display("FAIL reset data_o: got %h want 0", data_o); end
    endtask

    task automatic test_known();
        logic [127:0] keys [2];
        logic [127:0] cts  [2];
        logic [127:0] pts  [2];
        int lat, lat_exp;
        keys[0] = 128'h000102030405060708090a0b0c0d0e0f;
        cts[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        pts[0]  = 128'h00112233445566778899aabbccddeeff;
        keys[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        cts[1]  = 128'h3925841d02dc09fbdc118597196a0b32;
        pts[1]  = 128'h3243f6a8885a308d313198a2e0370734;
        for (int i = 0; i < 2; i++) begin
            do_accept(keys[i], cts[i], lat_exp);
            n_vec++;
            if (ready_o !== 1'b0) begin n_err++; $display("FAIL known%0d busy ready_o: got %b want 0", i, ready_o); end
            wait_valid(lat);
            n_vec++;
            if (lat != lat_exp) begin n_err++; $display("FAIL known%0d latency: got %0d want %0d", i, lat, lat_exp); end
            n_vec++;
            if (data_o !== pts[i]) begin n_err++; $display("FAIL known%0d data_o: got %h want %h", i, data_o, pts[i]); end
            retire();
            n_vec++;
            if (ready_o !== 1'b1 || v_o !== 1'b0) begin
                n_err++; $display("FAIL known%0d retire: got ready=%b v=%b want ready=1 v=0", i, ready_o, v_o);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] key, pt, ct;
        int lat, lat_exp;
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < 10; i++) begin
            if (i % 3 != 1) key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            ct = aes_enc(pt, key);
            do_accept(key, ct, lat_exp);
            wait_valid(lat);
            n_vec++;
            if (lat != lat_exp) begin n_err++; $display("FAIL rand%0d latency: got %0d want %0d", i, lat, lat_exp); end
            n_vec++;
            if (data_o !== pt) begin n_err++; $display("FAIL rand%0d data_o: got %h want %h", i, data_o, pt); end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            n_vec++;
            if (v_o !== 1'b1 || data_o !== pt) begin
                n_err++; $display("FAIL rand%0d hold: got v=%b %h want v=1 %h", i, v_o, data_o, pt);
            end
            retire();
        end
    endtask

    task automatic test_hold();
        logic [127:0] key, pt, ct;
        int lat, lat_exp;
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
        ct  = aes_enc(pt, key);
        do_accept(key, ct, lat_exp);
        wait_valid(lat);
        n_vec++;
        if (lat != lat_exp) begin n_err++; $display("FAIL hold latency: got %0d want %0d", lat, lat_exp); end
        for (int c = 0; c < 50; c++) begin
            v_i = 1'($urandom_range(0, 1));
            scramble_data();
            @(posedge clk);
            #1;
            n_vec++;
            if (v_o !== 1'b1 || ready_o !== 1'b0 || data_o !== pt) begin
                n_err++;
                $display("FAIL hold cycle %0d: got v=%b ready=%b %h want v=1 ready=0 %h",
                         c, v_o, ready_o, data_o, pt);
            end
        end
        v_i = 1'b1;
        retire();
        v_i = 1'b0;
        n_vec++;
        if (ready_o !== 1'b1 || v_o !== 1'b0) begin
            n_err++; $display("FAIL hold retire: got ready=%b v=%b want ready=1 v=0", ready_o, v_o);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (ready_o !== 1'b1) begin n_err++; $display("FAIL no same-cycle accept ready_o: got %b want 1", ready_o); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] key, pt, ct;
        int lat, lat_exp;
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
        ct  = aes_enc(pt, key);
        do_accept(key, ct, lat_exp);
        repeat (11) @(posedge clk);
        #1;
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        m_cv    = 1'b0;
        n_vec++;
        if (v_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 128'h0) begin
            n_err++;
            $display("FAIL midreset: got v=%b ready=%b %h want v=0 ready=1 0", v_o, ready_o, data_o);
        end
        repeat (12) @(posedge clk);
        #1;
        n_vec++;
        if (v_o !== 1'b0) begin n_err++; $display("FAIL midreset aborted v_o: got %b want 0", v_o); end
        pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        ct = aes_enc(pt, key);
        do_accept(key, ct, lat_exp);
        wait_valid(lat);
        n_vec++;
        if (lat != lat_exp) begin n_err++; $display("FAIL midreset fresh latency: got %0d want %0d", lat, lat_exp); end
        n_vec++;
        if (data_o !== pt) begin n_err++; $display("FAIL midreset fresh data_o: got %h want %h", data_o, pt); end
        retire();
    endtask

    task automatic test_back_to_back();
        logic [127:0] keys [3];
        logic [127:0] pt, ct;
        int lat, lat_exp;
        keys[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
        keys[1] = keys[0];
        keys[2] = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < 3; i++) begin
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            ct = aes_enc(pt, keys[i]);
            do_accept(keys[i], ct, lat_exp);
            wait_valid(lat);
            n_vec++;
            if (lat != lat_exp) begin n_err++; $display("FAIL b2b%0d latency: got %0d want %0d", i, lat, lat_exp); end
            n_vec++;
            if (data_o !== pt) begin n_err++; $display("FAIL b2b%0d data_o: got %h want %h", i, data_o, pt); end
            retire();
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_known();
        test_random();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
